// File: rtl/bcd_to_bin.sv
// Iterative six-digit BCD to 20-bit binary converter (Horner, MSD first, one digit per clock).
// Optional invalid-digit detection is compiled in with the BCD_CHECK_EN macro.
module bcd_to_bin #(
  parameter int DIGITS = 6,
  parameter int DATA_W = 20
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        unit,
  input  logic [3:0]        ten,
  input  logic [3:0]        hun,
  input  logic [3:0]        tho,
  input  logic [3:0]        t_tho,
  input  logic [3:0]        h_hun,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data,
  output logic              err,
  output logic [1:0]        dbg_state
);

  // Handshakes: a digit set transfers on an edge with in_valid && in_ready;
  // a result transfers on an edge with out_valid && out_ready. Once raised,
  // out_valid, data and err hold until that transfer happens.

  localparam int SR_W  = 4 * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [SR_W-1:0]     shift_q, shift_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                err_q, err_d;
  logic                err_cap_q, err_cap_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;

  logic [SR_W-1:0]     digits_in;
  logic [3:0]          head;
  logic [DATA_W-1:0]   acc_step;
  logic                digit_err;
  logic                last_digit;

  assign digits_in  = {h_hun, t_tho, tho, hun, ten, unit};
  assign head       = shift_q[SR_W-1 -: 4];
  // acc*10 as two shifts; the sum wraps at DATA_W bits by construction.
  assign acc_step   = (acc_q << 3) + (acc_q << 1) + {{(DATA_W-4){1'b0}}, head};
  assign last_digit = (cnt_q == CNT_W'(DIGITS - 1));

`ifdef BCD_CHECK_EN
  always_comb begin
    digit_err = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digits_in[i*4 +: 4] > 4'd9) digit_err = 1'b1;
    end
  end
`else
  assign digit_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    err_d     = err_q;
    err_cap_d = err_cap_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          shift_d   = digits_in;
          acc_d     = '0;
          cnt_d     = '0;
          err_cap_d = digit_err;
          state_d   = S_CONV;
        end
      end
      S_CONV: begin
        acc_d   = acc_step;
        shift_d = shift_q << 4;
        cnt_d   = cnt_q + 1'b1;
        if (last_digit) begin
          data_d  = err_cap_q ? '0 : acc_step;
          err_d   = err_cap_q;
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
      err_cap_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      err_q       <= err_d;
      err_cap_q   <= err_cap_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data      = data_q;
  assign err       = err_q;
  assign dbg_state = state_q;

`ifndef SYNTHESIS
  a_ready_valid_excl: assert property (@(posedge sys_clk) disable iff (sys_rst)
    !(in_ready && out_valid));
  a_result_hold: assert property (@(posedge sys_clk) disable iff (sys_rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(data) && $stable(err)));
`endif

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: directed cases plus randomized traffic
// scored against a positional-weight decimal model.
module tb_bcd_to_bin;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] dig;
  logic [3:0]  unit, ten, hun, tho, t_tho, h_hun;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] data;
  logic        err;
  logic [1:0]  dbg_state;

  assign {h_hun, t_tho, tho, hun, ten, unit} = dig;

  bcd_to_bin dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .unit     (unit),
    .ten      (ten),
    .hun      (hun),
    .tho      (tho),
    .t_tho    (t_tho),
    .h_hun    (h_hun),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data     (data),
    .err      (err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 sys_clk = ~sys_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_results = 0;
  logic [20:0] exp_q[$];
  bit          rand_ready_en = 1'b0;
  bit          prev_hold = 1'b0;
  logic [20:0] prev_word;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Decimal value as sum of digit * 10^position, reduced to 20 bits.
  function automatic logic [20:0] model(input logic [23:0] d);
    int v = 0;
    int p = 1;
`ifdef BCD_CHECK_EN
    bit bad = 1'b0;
`endif
    for (int k = 0; k < 6; k++) begin
      v = v + int'(d[k*4 +: 4]) * p;
      p = p * 10;
`ifdef BCD_CHECK_EN
      if (d[k*4 +: 4] > 4'd9) bad = 1'b1;
`endif
    end
`ifdef BCD_CHECK_EN
    if (bad) return {1'b1, 20'd0};
`endif
    return {1'b0, v[19:0]};
  endfunction

  function automatic logic [23:0] rand_digits(input bit allow_bad);
    logic [23:0] r;
    for (int k = 0; k < 6; k++) begin
      if (allow_bad && $urandom_range(0, 7) == 0) r[k*4 +: 4] = 4'($urandom_range(10, 15));
      else r[k*4 +: 4] = 4'($urandom_range(0, 9));
    end
    return r;
  endfunction

  // Acceptance monitor: inputs are stable from posedge+1 to the next posedge.
  always @(negedge sys_clk) begin
    if (!sys_rst && in_ready && in_valid) exp_q.push_back(model(dig));
  end

  // Compare process: result at every output transfer, stability while stalled.
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_word", 32'({err, data}), 32'(prev_word));
      end
      if (out_valid && out_ready) begin
        n_results++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL result_unexpected: got 0x%0h with no accepted input", {err, data});
        end else begin
          check("result", 32'({err, data}), 32'(exp_q.pop_front()));
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_word = {err, data};
    end
  end

  always @(posedge sys_clk) begin
    #1;
    if (rand_ready_en) out_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Present one digit set while idle, then count edges until out_valid.
  task automatic convert(input logic [23:0] d, input logic rdy, output int cycles);
    dig       = d;
    in_valid  = 1'b1;
    out_ready = rdy;
    tick();
    in_valid = 1'b0;
    cycles = 0;
    while (!out_valid && cycles < 50) begin
      tick();
      cycles++;
    end
  endtask

  task automatic drain();
    int guard = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || !in_ready) && guard < 100) begin
      tick();
      guard++;
    end
    tick();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int res0;
    logic [20:0] word;

    sys_rst   = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dig       = 24'h0;
    tick();
    tick();
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_data", 32'(data), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    sys_rst = 1'b0;
    tick();

    check("model_987654", 32'(model(24'h987654)), 32'h0F1206);
    check("model_999999", 32'(model(24'h999999)), 32'h0F423F);
    check("model_123456", 32'(model(24'h123456)), 32'h01E240);

    // Latency and first result.
    convert(24'h987654, 1'b1, cyc);
    check("latency", 32'(cyc), 32'd6);
    check("data_987654", 32'(data), 32'hF1206);
    check("err_987654", 32'(err), 32'd0);
    tick();
    check("idle_after_take", 32'(in_ready), 32'd1);
    check("valid_drop", 32'(out_valid), 32'd0);

    convert(24'h999999, 1'b1, cyc);
    check("data_999999", 32'(data), 32'hF423F);
    tick();
    convert(24'h000000, 1'b1, cyc);
    check("data_000000", 32'(data), 32'h0);
    tick();

    // Stall in DONE with ignored in_valid pulses.
    convert(24'h000001, 1'b0, cyc);
    check("data_000001", 32'(data), 32'h1);
    word = {err, data};
    for (int i = 0; i < 5; i++) begin
      dig      = rand_digits(1'b0);
      in_valid = 1'($urandom_range(0, 1));
      tick();
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_word", 32'({err, data}), 32'(word));
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("stall_release_idle", 32'(in_ready), 32'd1);
    check("stall_release_valid", 32'(out_valid), 32'd0);
    check("retain_data", 32'(data), 32'h1);

    // Invalid digits.
`ifdef BCD_CHECK_EN
    convert(24'h0000A0, 1'b1, cyc);
    check("bad_digit_err", 32'(err), 32'd1);
    check("bad_digit_data", 32'(data), 32'd0);
`else
    convert(24'hFFFFFF, 1'b1, cyc);
    check("all_f_data", 32'(data), 32'h96E69);
    check("all_f_err", 32'(err), 32'd0);
`endif
    tick();

    // Reset on the third conversion edge.
    dig      = 24'h555555;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    dig      = 24'h0;
    tick();
    tick();
    sys_rst = 1'b1;
    tick();
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_data", 32'(data), 32'd0);
    sys_rst = 1'b0;
    exp_q.delete();
    convert(24'h123456, 1'b1, cyc);
    check("data_123456", 32'(data), 32'h1E240);
    check("latency_after_rst", 32'(cyc), 32'd6);
    tick();

    // Back-to-back: in_valid held, digits change every cycle.
    res0      = n_results;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 64; i++) begin
      dig = rand_digits(1'b0);
      tick();
    end
    drain();
    check("b2b_throughput", 32'((n_results - res0) >= 7), 32'd1);

    // Randomized traffic with random output back-pressure.
    rand_ready_en = 1'b1;
    for (int t = 0; t < 40; t++) begin
      int guard;
      bit rdy;
      repeat ($urandom_range(0, 3)) tick();
      dig      = rand_digits(1'b1);
      in_valid = 1'b1;
      guard    = 0;
      rdy      = 1'b0;
      while (!rdy && guard < 100) begin
        rdy = in_ready;
        tick();
        guard++;
      end
      if (!rdy) begin
        n_checks++;
        $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", guard);
      end
      in_valid = 1'b0;
      dig      = rand_digits(1'b1);
    end
    rand_ready_en = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
